// File: rtl/ram_port_arbiter_pkg.sv
// Shared sizing and FSM encoding for the two-requester RAM port arbiter.
package ram_port_arbiter_pkg;
  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 16;
  localparam int NUM_REQ    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/dual_port_ram_16x8.sv
// Simple dual-port RAM: one write port, one registered read port, write-first on address collision.
module dual_port_ram_16x8
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Storage has no reset: contents survive rst and are cleared only by explicit writes.
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  always_ff @(posedge i_clk)
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ram_port_arbiter.sv
// Two requesters share one RAM; write and read ports each get an independent round-robin arbiter.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  output logic              init_busy,
  input  logic              a_wr_req,
  input  logic              b_wr_req,
  input  logic [ADDR_W-1:0] a_wr_addr,
  input  logic [ADDR_W-1:0] b_wr_addr,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic [DATA_W-1:0] b_wr_data,
  output logic              a_wr_gnt,
  output logic              b_wr_gnt,
  input  logic              a_rd_req,
  input  logic              b_rd_req,
  input  logic [ADDR_W-1:0] a_rd_addr,
  input  logic [ADDR_W-1:0] b_rd_addr,
  output logic              a_rd_gnt,
  output logic              b_rd_gnt,
  output logic              a_rd_valid,
  output logic              b_rd_valid,
  output logic [DATA_W-1:0] a_rd_data,
  output logic [DATA_W-1:0] b_rd_data
);
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_wr_ptr, r_rd_ptr;  // 0: A holds priority, 1: B holds priority
  logic              w_arb_en, w_busy;
  logic              r_a_rd_valid, r_b_rd_valid;
  logic [DATA_W-1:0] r_a_rd_hold, r_b_rd_hold;
  logic              w_ram_we, w_ram_re;
  logic [ADDR_W-1:0] w_ram_waddr, w_ram_raddr;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gating on rst_n keeps grants low while reset is asserted.
        w_arb_en = rst_n;
        if (init_start) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_busy = 1'b1;
        if (r_clr_cnt == '1) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign init_busy = w_busy;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                  r_clr_cnt <= '0;
    else if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;

  assign a_wr_gnt = w_arb_en && a_wr_req && (!b_wr_req || !r_wr_ptr);
  assign b_wr_gnt = w_arb_en && b_wr_req && (!a_wr_req ||  r_wr_ptr);
  assign a_rd_gnt = w_arb_en && a_rd_req && (!b_rd_req || !r_rd_ptr);
  assign b_rd_gnt = w_arb_en && b_rd_req && (!a_rd_req ||  r_rd_ptr);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (a_wr_gnt)      r_wr_ptr <= 1'b1;
      else if (b_wr_gnt) r_wr_ptr <= 1'b0;
      if (a_rd_gnt)      r_rd_ptr <= 1'b1;
      else if (b_rd_gnt) r_rd_ptr <= 1'b0;
    end

  always_comb begin
    w_ram_we    = a_wr_gnt || b_wr_gnt;
    w_ram_waddr = b_wr_gnt ? b_wr_addr : a_wr_addr;
    w_ram_wdata = b_wr_gnt ? b_wr_data : a_wr_data;
    if (r_state == ST_CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_clr_cnt;
      w_ram_wdata = '0;
    end
  end

  assign w_ram_re    = a_rd_gnt || b_rd_gnt;
  assign w_ram_raddr = b_rd_gnt ? b_rd_addr : a_rd_addr;

  dual_port_ram_16x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .i_clk   (clk),
    .i_rst   (1'b0),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  // RAM output only moves on a granted read, so it is stable for the valid cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a_rd_valid <= 1'b0;
      r_b_rd_valid <= 1'b0;
      r_a_rd_hold  <= '0;
      r_b_rd_hold  <= '0;
    end else begin
      r_a_rd_valid <= a_rd_gnt;
      r_b_rd_valid <= b_rd_gnt;
      if (r_a_rd_valid) r_a_rd_hold <= w_ram_rdata;
      if (r_b_rd_valid) r_b_rd_hold <= w_ram_rdata;
    end

  assign a_rd_valid = r_a_rd_valid;
  assign b_rd_valid = r_b_rd_valid;
  assign a_rd_data  = r_a_rd_valid ? w_ram_rdata : r_a_rd_hold;
  assign b_rd_data  = r_b_rd_valid ? w_ram_rdata : r_b_rd_hold;
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width (16 locations).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 init_start  input  1  one-cycle pulse; starts clearing all locations to zero.
REQ-006 init_busy  output  1  high while the clear sequence runs.
REQ-007 a_wr_req, b_wr_req  input  1  write request per requester.
REQ-008 a_wr_addr, b_wr_addr  input  ADDR_W  write address.
REQ-009 a_wr_data, b_wr_data  input  DATA_W  write data.
REQ-010 a_wr_gnt, b_wr_gnt  output  1  write grant; write commits at the edge ending the grant cycle.
REQ-011 a_rd_req, b_rd_req  input  1  read request per requester.
REQ-012 a_rd_addr, b_rd_addr  input  ADDR_W  read address.
REQ-013 a_rd_gnt, b_rd_gnt  output  1  read grant.
REQ-014 a_rd_valid, b_rd_valid  output  1  read data valid, one cycle.
REQ-015 a_rd_data, b_rd_data  output  DATA_W  read data, meaningful only while the matching rd_valid is high.

Function
REQ-016 The write port and the read port SHALL be arbitrated independently, each with its own round-robin pointer.
REQ-017 Grants SHALL be combinational from the current-cycle requests; at most one wr_gnt and one rd_gnt per cycle.
REQ-018 Single requester on a port SHALL be granted the same cycle.
REQ-019 If both request a port, the pointer holder SHALL win; after any grant the pointer SHALL move to the non-granted requester.
REQ-020 Requesters SHALL hold req/addr/data stable until grant; a granted req may stay high for back-to-back grants.
REQ-021 A granted write SHALL drive RAM we=1 with the granted addr/data for exactly that cycle.
REQ-022 A granted read SHALL drive RAM re=1; the matching rd_valid SHALL rise the next cycle with rd_data. Read latency is 1 cycle.
REQ-023 Same-cycle granted read and write to the same address SHALL return the newly written data (write-first forwarding).
REQ-024 A non-selected rd_data SHALL hold its last value; the other requester's rd_valid SHALL stay low.
REQ-025 FSM states: IDLE, CLEAR. IDLE->CLEAR on init_start; CLEAR writes 0x00 to addresses 0..15, one per cycle; after address 15 -> IDLE. No wrap beyond 15.
REQ-026 init_busy SHALL be high for exactly 16 cycles, starting the cycle after init_start.
REQ-027 In CLEAR all grants SHALL be low and pointers frozen; an rd_valid already pending from the preceding cycle SHALL still be delivered.
REQ-028 init_start while busy SHALL be ignored.
REQ-029 init_start coinciding with requests in IDLE: that cycle's grants SHALL proceed normally, and CLEAR begins the next cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force: FSM IDLE, clear counter 0, init_busy 0, all gnt 0, all rd_valid 0, all rd_data 0, both pointers favouring A.
REQ-031 Reset SHALL NOT clear RAM contents; the RAM's own rst is tied inactive, and clearing is done only via init_start.
REQ-032 Reset mid-CLEAR SHALL abort the sequence; already-cleared locations stay zero and the rest keep their data.

Structure
REQ-033 A shared package SHALL hold ADDR_W, DATA_W, depth 16, the requester count 2, and the FSM state encoding.
REQ-034 dual_port_ram_16x8 SHALL be the single instantiated sub-module; its write and read ports are driven only by this block.

Verification
REQ-035 Reset, then A writes 0xA5 @1 alone -> a_wr_gnt the same cycle; A reads @1 -> a_rd_valid next cycle, a_rd_data 0xA5.
REQ-036 A and B both write each cycle for 4 cycles (A: 0x11 @2, B: 0x22 @3) -> grants alternate A,B,A,B; a later read returns 0x11 @2 and 0x22 @3.
REQ-037 A writes 0x3C @5 while B reads @5 in the same cycle -> b_rd_valid next cycle, b_rd_data 0x3C.
REQ-038 Fill addresses 0..15 with 0xFF, pulse init_start with requests held -> init_busy for 16 cycles, no grants; afterwards every read returns 0x00.
REQ-039 Assert rst_n low at clear cycle 8 -> outputs reset immediately; addresses 0..7 read 0x00, addresses 8..15 read 0xFF.
